// File: rtl/avm_bridge_pkg.sv
// Shared definitions for the Avalon-MM bridge: transfer states and fixed bus constants.
package avm_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_e;

  localparam logic [3:0] BYTEENABLE         = 4'b1111;
  localparam int         WORD_SHIFT         = 2;
  localparam int         DEFAULT_FIFO_DEPTH = 4;

endpackage

// File: rtl/avm_bridge_fifo.sv
// Request queue: synchronous FIFO with extra wrap bit on each pointer and a
// first-word-fall-through head (dout_o is valid whenever empty_o is low).
module avm_bridge_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // Next pointer values; each advances by one entry and wraps naturally.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  // Pointer registers; reset empties the queue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/avm_bridge.sv
// Accelerator-to-Avalon-MM master bridge. Requests are queued, then issued one
// at a time on the Avalon master port with fully registered bus outputs.
//
//   state | meaning
//   IDLE  | no transfer on the bus; next queued request is launched here
//   RD    | m0_read asserted, waiting for waitrequest low
//   WR    | m0_write asserted, waiting for waitrequest low
module avm_bridge
  import avm_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  AVM_BRIDGE_Clk,
  input  logic                  AVM_BRIDGE_Reset,
  input  logic [ADDR_WIDTH-1:0] AVM_BRIDGE_Acc_Addr,
  input  logic                  AVM_BRIDGE_Acc_Re,
  input  logic                  AVM_BRIDGE_Acc_We,
  input  logic [DATA_WIDTH-1:0] AVM_BRIDGE_Acc_Wdata,
  output logic                  AVM_BRIDGE_Acc_Stall,
  output logic [DATA_WIDTH-1:0] AVM_BRIDGE_Acc_Rdata,
  output logic                  AVM_BRIDGE_Acc_Rvalid,
  output logic                  AVM_BRIDGE_Acc_Idle,
  output logic                  AVM_BRIDGE_Err,
  output logic [17:0]           AVM_BRIDGE_m0_adress,
  output logic                  AVM_BRIDGE_m0_read,
  output logic                  AVM_BRIDGE_m0_write,
  output logic [31:0]           AVM_BRIDGE_m0_writedata,
  output logic [3:0]            AVM_BRIDGE_m0_byteenable,
  input  logic [31:0]           AVM_BRIDGE_m0_readdata,
  input  logic                  AVM_BRIDGE_m0_waitrequest
);

  // Queue entry layout: {is_write, addr[15:0], wdata}
  localparam int EW = 1 + 16 + DATA_WIDTH;

  state_e                state_q;
  logic                  read_q;
  logic                  write_q;
  logic [17:0]           adr_q;
  logic [31:0]           wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;
  logic                  err_q;

  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [EW-1:0]         din;
  logic [EW-1:0]         head;
  logic                  head_w;
  logic [15:0]           head_a;
  logic [DATA_WIDTH-1:0] head_d;
  logic                  unused_bits;

  // A write wins when both strobes are high; the read is dropped.
  assign push = (AVM_BRIDGE_Acc_Re | AVM_BRIDGE_Acc_We) & ~full;
  assign din  = {AVM_BRIDGE_Acc_We, AVM_BRIDGE_Acc_Addr[15:0], AVM_BRIDGE_Acc_Wdata};

  assign head_w = head[EW-1];
  assign head_a = head[EW-2 -: 16];
  assign head_d = head[DATA_WIDTH-1:0];

  // Launch the head when the bus is free or the current transfer finishes now.
  assign pop = ~empty & ((state_q == IDLE) | ~AVM_BRIDGE_m0_waitrequest);

  assign unused_bits = ^{AVM_BRIDGE_Acc_Addr[ADDR_WIDTH-1:16], AVM_BRIDGE_m0_readdata[31:DATA_WIDTH]};

  avm_bridge_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i   (AVM_BRIDGE_Clk),
    .rst_i   (AVM_BRIDGE_Reset),
    .push_i  (push),
    .din_i   (din),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Transfer FSM with registered Avalon outputs and read-return capture.
  always_ff @(posedge AVM_BRIDGE_Clk) begin
    if (AVM_BRIDGE_Reset) begin
      state_q  <= IDLE;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      adr_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (AVM_BRIDGE_Acc_Re && AVM_BRIDGE_Acc_We) err_q <= 1'b1;

      if (state_q == RD && !AVM_BRIDGE_m0_waitrequest) begin
        rdata_q  <= AVM_BRIDGE_m0_readdata[DATA_WIDTH-1:0];
        rvalid_q <= 1'b1;
      end

      if (pop) begin
        state_q <= head_w ? WR : RD;
        read_q  <= ~head_w;
        write_q <= head_w;
        adr_q   <= 18'(32'(head_a) << WORD_SHIFT);
        wdata_q <= 32'($signed(head_d));
      end else if (state_q != IDLE && !AVM_BRIDGE_m0_waitrequest) begin
        state_q <= IDLE;
        read_q  <= 1'b0;
        write_q <= 1'b0;
      end
    end
  end

  assign AVM_BRIDGE_Acc_Stall     = full;
  assign AVM_BRIDGE_Acc_Idle      = empty & (state_q == IDLE);
  assign AVM_BRIDGE_Acc_Rdata     = rdata_q;
  assign AVM_BRIDGE_Acc_Rvalid    = rvalid_q;
  assign AVM_BRIDGE_Err           = err_q;
  assign AVM_BRIDGE_m0_adress     = adr_q;
  assign AVM_BRIDGE_m0_read       = read_q;
  assign AVM_BRIDGE_m0_write      = write_q;
  assign AVM_BRIDGE_m0_writedata  = wdata_q;
  assign AVM_BRIDGE_m0_byteenable = BYTEENABLE;

endmodule
